// File: rtl/alu_div.sv
// Iterative radix-2 restoring divider for DIV.W / MOD.W / DIV.WU / MOD.WU, one request at a time.
// Optional DIV_ZERO_FAST_EN: a zero divisor skips the iterations and finishes one cycle after accept.
module alu_div (
    input  logic        clk,
    input  logic        reset,
    input  logic        div_valid,
    output logic        div_ready,
    input  logic        div_signed,
    input  logic        div_mod,
    input  logic [31:0] div_src1,
    input  logic [31:0] div_src2,
    input  logic        div_flush,
    output logic        div_busy,
    output logic        div_done,
    output logic [31:0] div_result
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state, state_nxt;
    logic        accept;
    logic        last;
    logic [5:0]  cnt;
    logic [32:0] rem;
    logic [31:0] quo;
    logic [31:0] dsr;
    logic [31:0] src1_raw;
    logic        qneg, rneg, mod_q, zero_q;
    logic [33:0] trial;
    logic        borrow;
    logic [32:0] rem_nxt;
    logic [31:0] quo_nxt;

    function automatic logic [31:0] neg32(input logic [31:0] x);
        return ~x + 32'd1;
    endfunction

    function automatic logic [31:0] mag32(input logic [31:0] x, input logic sgn);
        return (sgn && x[31]) ? neg32(x) : x;
    endfunction

    // Divide-by-zero bypasses the sign fix: all-ones quotient, untouched dividend as remainder.
    function automatic logic [31:0] fix_result(
        input logic [31:0] q,
        input logic [31:0] r,
        input logic        q_n,
        input logic        r_n,
        input logic        zero,
        input logic        md,
        input logic [31:0] raw
    );
        if (zero)
            return md ? raw : 32'hFFFF_FFFF;
        else if (md)
            return r_n ? neg32(r) : r;
        else
            return q_n ? neg32(q) : q;
    endfunction

    assign accept = div_valid & div_ready & ~div_flush;
    assign last   = (cnt == 6'd31);

    // One iteration: shift {rem, quo} left, trial-subtract the divisor magnitude, restore on borrow.
    assign trial   = {rem, quo[31]} - {2'b00, dsr};
    assign borrow  = trial[33];
    assign rem_nxt = borrow ? {rem[31:0], quo[31]} : trial[32:0];
    assign quo_nxt = {quo[30:0], ~borrow};

    assign div_ready = (state == IDLE);
    assign div_busy  = (state != IDLE);
    assign div_done  = (state == DONE) & ~div_flush;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
`ifdef DIV_ZERO_FAST_EN
                    state_nxt = (div_src2 == 32'd0) ? DONE : CALC;
`else
                    state_nxt = CALC;
`endif
                end
            end
            CALC: begin
                if (div_flush)
                    state_nxt = IDLE;
                else if (last)
                    state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= 6'd0;
            div_result <= 32'd0;
        end else begin
            state <= state_nxt;
            if (accept)
                cnt <= 6'd0;
            else if (state == CALC)
                cnt <= cnt + 6'd1;
            if (state == CALC && last && !div_flush)
                div_result <= fix_result(quo_nxt, rem_nxt[31:0], qneg, rneg, zero_q, mod_q, src1_raw);
`ifdef DIV_ZERO_FAST_EN
            else if (accept && div_src2 == 32'd0)
                div_result <= div_mod ? div_src1 : 32'hFFFF_FFFF;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mod_q    <= div_mod;
            src1_raw <= div_src1;
            quo      <= mag32(div_src1, div_signed);
            dsr      <= mag32(div_src2, div_signed);
            qneg     <= div_signed & (div_src1[31] ^ div_src2[31]);
            rneg     <= div_signed & div_src1[31];
            zero_q   <= (div_src2 == 32'd0);
            rem      <= 33'd0;
        end else if (state == CALC) begin
            rem <= rem_nxt;
            quo <= quo_nxt;
        end
    end

endmodule

// File: tb/tb_alu_div.sv
// Scoreboard bench for alu_div: stimulus pushes expected result and done cycle, a monitor pops on div_done.
module tb_alu_div;

    logic        clk = 1'b0;
    logic        reset;
    logic        div_valid;
    logic        div_ready;
    logic        div_signed;
    logic        div_mod;
    logic [31:0] div_src1;
    logic [31:0] div_src2;
    logic        div_flush;
    logic        div_busy;
    logic        div_done;
    logic [31:0] div_result;

`ifdef DIV_ZERO_FAST_EN
    localparam int ZLAT = 0;
`else
    localparam int ZLAT = 32;
`endif
    localparam int LAT = 32;

    typedef struct {
        logic [31:0] res;
        int          at;
        string       name;
    } exp_t;

    exp_t sbq[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    alu_div dut (
        .clk        (clk),
        .reset      (reset),
        .div_valid  (div_valid),
        .div_ready  (div_ready),
        .div_signed (div_signed),
        .div_mod    (div_mod),
        .div_src1   (div_src1),
        .div_src2   (div_src2),
        .div_flush  (div_flush),
        .div_busy   (div_busy),
        .div_done   (div_done),
        .div_result (div_result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (div_done) begin
                if (sbq.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_done: got done with result %h, expected no done", div_result);
                end else begin
                    e = sbq.pop_front();
                    chk({e.name, "_result"}, div_result, e.res);
                    chk({e.name, "_cycle"}, 32'(cyc), 32'(e.at));
                end
            end
        end
    endtask

    task automatic start_op(input bit sg, input bit md, input logic [31:0] a, input logic [31:0] b,
                            output bit ok);
        int w = 0;
        @(negedge clk);
        while (!div_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        ok = div_ready;
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL ready_timeout: got ready=0, expected ready=1");
            return;
        end
        div_signed = sg;
        div_mod    = md;
        div_src1   = a;
        div_src2   = b;
        div_valid  = 1'b1;
        @(posedge clk);
        #1;
        div_valid = 1'b0;
    endtask

    task automatic issue(input string nm, input bit sg, input bit md, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int lat);
        bit   ok;
        exp_t e;
        start_op(sg, md, a, b, ok);
        if (ok) begin
            e.res  = exp;
            e.at   = cyc + lat;
            e.name = nm;
            sbq.push_back(e);
        end
    endtask

    task automatic drain();
        int w = 0;
        while (sbq.size() != 0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (sbq.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: got %0d pending, expected 0", sbq.size());
            sbq.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        bit ok;
        reset      = 1'b1;
        div_valid  = 1'b0;
        div_signed = 1'b0;
        div_mod    = 1'b0;
        div_src1   = 32'd0;
        div_src2   = 32'd0;
        div_flush  = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        fork
            monitor();
        join_none
        @(negedge clk);
        chk("rst_ready",  32'(div_ready), 32'd1);
        chk("rst_busy",   32'(div_busy),  32'd0);
        chk("rst_done",   32'(div_done),  32'd0);
        chk("rst_result", div_result,     32'd0);

        // Main function, one op at a time
        issue("u100d7",  0, 0, 32'd100,      32'd7,        32'd14,       LAT); drain();
        issue("u100m7",  0, 1, 32'd100,      32'd7,        32'd2,        LAT); drain();
        issue("sm7d2",   1, 0, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, LAT); drain();
        issue("sm7m2",   1, 1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, LAT); drain();
        issue("s7dm2",   1, 0, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, LAT); drain();
        issue("s7mm2",   1, 1, 32'd7,        32'hFFFFFFFE, 32'h00000001, LAT); drain();
        issue("ufd2",    0, 0, 32'hFFFFFFFF, 32'd2,        32'h7FFFFFFF, LAT); drain();
        issue("ufm2",    0, 1, 32'hFFFFFFFF, 32'd2,        32'h00000001, LAT); drain();
        issue("ovf_q",   1, 0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, LAT); drain();
        issue("ovf_r",   1, 1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, LAT); drain();
        issue("z_sq",    1, 0, 32'h12345678, 32'd0,        32'hFFFFFFFF, ZLAT); drain();
        issue("z_sr",    1, 1, 32'h12345678, 32'd0,        32'h12345678, ZLAT); drain();
        issue("z_uq",    0, 0, 32'h12345678, 32'd0,        32'hFFFFFFFF, ZLAT); drain();
        issue("z_ur",    0, 1, 32'h12345678, 32'd0,        32'h12345678, ZLAT); drain();
        issue("z_negr",  1, 1, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, ZLAT); drain();

        // New request while busy is ignored
        issue("ign", 0, 0, 32'd100, 32'd7, 32'd14, LAT);
        repeat (3) @(negedge clk);
        div_src1  = 32'd50;
        div_src2  = 32'd5;
        div_valid = 1'b1;
        repeat (4) @(negedge clk);
        div_valid = 1'b0;
        drain();
        repeat (3) @(negedge clk);
        chk("hold_result", div_result, 32'd14);

        // Flush at iteration 10
        start_op(0, 0, 32'd1000, 32'd3, ok);
        repeat (10) @(posedge clk);
        #1 div_flush = 1'b1;
        @(posedge clk);
        #1 div_flush = 1'b0;
        @(negedge clk);
        chk("flush_ready",  32'(div_ready), 32'd1);
        chk("flush_busy",   32'(div_busy),  32'd0);
        chk("flush_result", div_result,     32'd14);
        issue("post_flush", 0, 0, 32'd50, 32'd5, 32'd10, LAT); drain();

        // Flush in DONE suppresses the done pulse
        start_op(0, 0, 32'd9, 32'd3, ok);
        repeat (LAT) @(posedge clk);
        #1 div_flush = 1'b1;
        @(negedge clk);
        chk("flush_done_busy", 32'(div_busy), 32'd1);
        chk("flush_done_done", 32'(div_done), 32'd0);
        @(posedge clk);
        #1 div_flush = 1'b0;
        @(negedge clk);
        chk("flush_done_ready", 32'(div_ready), 32'd1);

        // Flush together with valid in IDLE: no accept
        @(negedge clk);
        div_src1  = 32'd8;
        div_src2  = 32'd2;
        div_valid = 1'b1;
        div_flush = 1'b1;
        @(posedge clk);
        #1;
        div_valid = 1'b0;
        div_flush = 1'b0;
        @(negedge clk);
        chk("flush_valid_busy", 32'(div_busy), 32'd0);
        repeat (40) @(negedge clk);

        // Reset at iteration 20
        start_op(0, 0, 32'd1000, 32'd3, ok);
        repeat (20) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("mrst_busy",   32'(div_busy),  32'd0);
        chk("mrst_done",   32'(div_done),  32'd0);
        chk("mrst_result", div_result,     32'd0);
        chk("mrst_ready",  32'(div_ready), 32'd1);
        repeat (40) @(negedge clk);

        issue("after_rst", 0, 1, 32'd100, 32'd7, 32'd2, LAT); drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

endmodule
